// File: rtl/axis_tx_arbiter.sv
// Packet-granular round-robin arbiter: four AXI-Stream sources share one TX stream; a grant is held until the TLAST beat.
// One ARB cycle per packet, then a zero-latency pass; downstream TREADY reaches only the granted source.
module axis_tx_arbiter #(
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    port_enable,
  input  logic [DW-1:0] S0_AXIS_TDATA,
  input  logic [4:0]    S0_AXIS_TUSER,
  input  logic          S0_AXIS_TLAST,
  input  logic          S0_AXIS_TVALID,
  output logic          S0_AXIS_TREADY,
  input  logic [DW-1:0] S1_AXIS_TDATA,
  input  logic [4:0]    S1_AXIS_TUSER,
  input  logic          S1_AXIS_TLAST,
  input  logic          S1_AXIS_TVALID,
  output logic          S1_AXIS_TREADY,
  input  logic [DW-1:0] S2_AXIS_TDATA,
  input  logic [4:0]    S2_AXIS_TUSER,
  input  logic          S2_AXIS_TLAST,
  input  logic          S2_AXIS_TVALID,
  output logic          S2_AXIS_TREADY,
  input  logic [DW-1:0] S3_AXIS_TDATA,
  input  logic [4:0]    S3_AXIS_TUSER,
  input  logic          S3_AXIS_TLAST,
  input  logic          S3_AXIS_TVALID,
  output logic          S3_AXIS_TREADY,
  output logic [DW-1:0] AXIS_TX_TDATA,
  output logic [4:0]    AXIS_TX_TUSER,
  output logic          AXIS_TX_TLAST,
  output logic          AXIS_TX_TVALID,
  input  logic          AXIS_TX_TREADY,
  output logic [3:0]    grant,
  output logic [31:0]   pkt_count
);

  typedef enum logic {ARB, PASS} state_t;

  typedef struct packed {
    logic [DW-1:0] tdata;
    logic [4:0]    tuser;
    logic          tlast;
    logic          tvalid;
  } beat_t;

  state_t     state, state_nxt;
  logic [1:0] sel, last, pick;
  logic       found;
  logic [3:0] cand;
  logic [3:0] tready_v;
  logic       tx_vld;
  logic       pkt_end;
  beat_t      src_beat [4];
  beat_t      sel_beat;

  assign src_beat[0] = '{S0_AXIS_TDATA, S0_AXIS_TUSER, S0_AXIS_TLAST, S0_AXIS_TVALID};
  assign src_beat[1] = '{S1_AXIS_TDATA, S1_AXIS_TUSER, S1_AXIS_TLAST, S1_AXIS_TVALID};
  assign src_beat[2] = '{S2_AXIS_TDATA, S2_AXIS_TUSER, S2_AXIS_TLAST, S2_AXIS_TVALID};
  assign src_beat[3] = '{S3_AXIS_TDATA, S3_AXIS_TUSER, S3_AXIS_TLAST, S3_AXIS_TVALID};

  assign cand = port_enable & {S3_AXIS_TVALID, S2_AXIS_TVALID, S1_AXIS_TVALID, S0_AXIS_TVALID};

  // Search last+1 .. last+4 (mod 4); the final probe lands back on last itself.
  always_comb begin : rr_pick
    logic [1:0] idx;
    found = 1'b0;
    pick  = last;
    idx   = last;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && cand[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin : fsm_comb
    state_nxt = state;
    sel_beat  = src_beat[sel];
    tready_v  = '0;
    tx_vld    = 1'b0;
    pkt_end   = 1'b0;
    case (state)
      ARB: begin
        if (found) state_nxt = PASS;
      end
      PASS: begin
        tx_vld        = sel_beat.tvalid;
        tready_v[sel] = AXIS_TX_TREADY & ~reset;
        pkt_end       = tx_vld & AXIS_TX_TREADY & sel_beat.tlast & ~reset;
        if (pkt_end) state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB;
      sel       <= 2'd0;
      last      <= 2'd3;
      grant     <= 4'b0000;
      pkt_count <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == ARB && found) begin
        sel   <= pick;
        last  <= pick;
        grant <= 4'b0001 << pick;
      end
      if (pkt_end) begin
        grant     <= 4'b0000;
        pkt_count <= pkt_count + 32'd1;
      end
    end
  end

  assign AXIS_TX_TDATA  = sel_beat.tdata;
  assign AXIS_TX_TUSER  = sel_beat.tuser;
  assign AXIS_TX_TLAST  = sel_beat.tlast;
  assign AXIS_TX_TVALID = tx_vld;

  assign S0_AXIS_TREADY = tready_v[0];
  assign S1_AXIS_TREADY = tready_v[1];
  assign S2_AXIS_TREADY = tready_v[2];
  assign S3_AXIS_TREADY = tready_v[3];

endmodule

// File: tb/tb_axis_tx_arbiter.sv
// Directed bench for axis_tx_arbiter: packet sources modelled per port, outputs checked against hand-derived schedules.
module tb_axis_tx_arbiter;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    port_enable = 4'hF;
  logic          tx_ready = 1'b1;
  logic [DW-1:0] s_tdata [4];
  logic [4:0]    s_tuser [4];
  logic [3:0]    s_tlast, s_tvalid, s_tready;
  logic [DW-1:0] AXIS_TX_TDATA;
  logic [4:0]    AXIS_TX_TUSER;
  logic          AXIS_TX_TLAST, AXIS_TX_TVALID;
  logic [3:0]    grant;
  logic [31:0]   pkt_count;

  logic [3:0]    src_on = 4'hF;
  int            src_len [4] = '{4, 4, 4, 4};
  int            beat_idx [4] = '{0, 0, 0, 0};
  int            pkt_idx [4] = '{0, 0, 0, 0};
  logic [DW+5:0] mon_q [$];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] beat_data(input int s, input int p, input int b);
    return {32'hA5A5_0000 | 32'(s), 32'(p), 32'(b), 32'(s * 256 + p * 16 + b)};
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      s_tvalid[i] = src_on[i];
      s_tlast[i]  = (beat_idx[i] == src_len[i] - 1);
      s_tdata[i]  = beat_data(i, pkt_idx[i], beat_idx[i]);
      s_tuser[i]  = 5'(i * 8 + beat_idx[i]);
    end
  end

  axis_tx_arbiter #(.DW(DW)) dut (
    .clk(clk), .reset(reset), .port_enable(port_enable),
    .S0_AXIS_TDATA(s_tdata[0]), .S0_AXIS_TUSER(s_tuser[0]), .S0_AXIS_TLAST(s_tlast[0]),
    .S0_AXIS_TVALID(s_tvalid[0]), .S0_AXIS_TREADY(s_tready[0]),
    .S1_AXIS_TDATA(s_tdata[1]), .S1_AXIS_TUSER(s_tuser[1]), .S1_AXIS_TLAST(s_tlast[1]),
    .S1_AXIS_TVALID(s_tvalid[1]), .S1_AXIS_TREADY(s_tready[1]),
    .S2_AXIS_TDATA(s_tdata[2]), .S2_AXIS_TUSER(s_tuser[2]), .S2_AXIS_TLAST(s_tlast[2]),
    .S2_AXIS_TVALID(s_tvalid[2]), .S2_AXIS_TREADY(s_tready[2]),
    .S3_AXIS_TDATA(s_tdata[3]), .S3_AXIS_TUSER(s_tuser[3]), .S3_AXIS_TLAST(s_tlast[3]),
    .S3_AXIS_TVALID(s_tvalid[3]), .S3_AXIS_TREADY(s_tready[3]),
    .AXIS_TX_TDATA(AXIS_TX_TDATA), .AXIS_TX_TUSER(AXIS_TX_TUSER), .AXIS_TX_TLAST(AXIS_TX_TLAST),
    .AXIS_TX_TVALID(AXIS_TX_TVALID), .AXIS_TX_TREADY(tx_ready),
    .grant(grant), .pkt_count(pkt_count)
  );

  // Source model: advance a port's beat on its handshake; a reset cycle restarts the packet in flight.
  initial forever begin
    logic [3:0] hs, lst;
    logic       rst_seen;
    @(negedge clk);
    rst_seen = reset;
    hs       = s_tvalid & s_tready;
    lst      = s_tlast;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (rst_seen) beat_idx[i] = 0;
      else if (hs[i]) begin
        if (lst[i]) begin
          beat_idx[i] = 0;
          pkt_idx[i]  = pkt_idx[i] + 1;
        end else beat_idx[i] = beat_idx[i] + 1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!reset && AXIS_TX_TVALID && tx_ready)
      mon_q.push_back({AXIS_TX_TUSER, AXIS_TX_TLAST, AXIS_TX_TDATA});
  end

  task automatic test_reset();
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (s_tready !== 4'b0000 || AXIS_TX_TVALID !== 1'b0) begin
        fails++;
        $display("FAIL rst_ready_valid: tready=%b tvalid=%b want 0000/0", s_tready, AXIS_TX_TVALID);
      end
      tests++;
      if (grant !== 4'b0000 || pkt_count !== 32'd0) begin
        fails++;
        $display("FAIL rst_grant_count: grant=%b count=%0d want 0000/0", grant, pkt_count);
      end
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    tests++;
    if (grant !== 4'b0000 || AXIS_TX_TVALID !== 1'b0) begin
      fails++;
      $display("FAIL rst_first_arb: grant=%b tvalid=%b want 0000/0", grant, AXIS_TX_TVALID);
    end
    @(negedge clk);
    tests++;
    if (grant !== 4'b0001 || s_tready !== 4'b0001) begin
      fails++;
      $display("FAIL rst_first_grant: grant=%b tready=%b want 0001/0001", grant, s_tready);
    end
  endtask

  // Cycle 0 was the first ARB cycle after release; each packet is 1 ARB + 4 PASS cycles.
  task automatic test_fairness();
    for (int c = 2; c <= 40; c++) begin
      @(negedge clk);
      if (c == 40) begin
        tests++;
        if (pkt_count !== 32'd8 || grant !== 4'b0000) begin
          fails++;
          $display("FAIL fair_count: count=%0d grant=%b want 8/0000", pkt_count, grant);
        end
        src_on = 4'h0;
      end else begin
        int         slot, src;
        logic [3:0] exp_g;
        slot  = c % 5;
        src   = (c / 5) % 4;
        exp_g = (slot == 0) ? 4'b0000 : (4'b0001 << src);
        tests++;
        if (grant !== exp_g) begin
          fails++;
          $display("FAIL fair_grant c=%0d: grant=%b want %b", c, grant, exp_g);
        end
        if (slot != 0) begin
          tests++;
          if (AXIS_TX_TDATA !== beat_data(src, c / 20, slot - 1) || AXIS_TX_TVALID !== 1'b1) begin
            fails++;
            $display("FAIL fair_data c=%0d: data=%h want %h", c, AXIS_TX_TDATA, beat_data(src, c / 20, slot - 1));
          end
        end
      end
    end
  endtask

  task automatic test_enable_mask();
    @(negedge clk);
    port_enable = 4'b1010;
    src_len[1]  = 2;
    src_len[3]  = 2;
    src_on      = 4'hF;
    for (int d = 1; d <= 12; d++) begin
      logic [3:0] exp_g;
      @(negedge clk);
      exp_g = (d % 3 == 0) ? 4'b0000 : (((d / 3) % 2 == 0) ? 4'b0010 : 4'b1000);
      tests++;
      if (grant !== exp_g) begin
        fails++;
        $display("FAIL mask_grant d=%0d: grant=%b want %b", d, grant, exp_g);
      end
      tests++;
      if ({s_tready[2], s_tready[0]} !== 2'b00) begin
        fails++;
        $display("FAIL mask_ready d=%0d: tready=%b want x0x0", d, s_tready);
      end
    end
    tests++;
    if (pkt_count !== 32'd12) begin
      fails++;
      $display("FAIL mask_count: count=%0d want 12", pkt_count);
    end
    src_on      = 4'h0;
    port_enable = 4'hF;
  endtask

  task automatic test_backpressure();
    int p2;
    @(negedge clk);
    p2         = pkt_idx[2];
    src_len[2] = 6;
    src_on     = 4'b0100;
    for (int k = 0; k <= 11; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) mon_q.delete();
      tx_ready = (k % 2 == 0);
      @(negedge clk);
      if (k <= 10) begin
        tests++;
        if (grant !== 4'b0100 || AXIS_TX_TVALID !== 1'b1) begin
          fails++;
          $display("FAIL bp_hold k=%0d: grant=%b tvalid=%b want 0100/1", k, grant, AXIS_TX_TVALID);
        end
      end else begin
        tests++;
        if (grant !== 4'b0000 || pkt_count !== 32'd13) begin
          fails++;
          $display("FAIL bp_end: grant=%b count=%0d want 0000/13", grant, pkt_count);
        end
        src_on   = 4'h0;
        tx_ready = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    tests++;
    if (mon_q.size() != 6) begin
      fails++;
      $display("FAIL bp_beats: got %0d beats want 6", mon_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        logic [DW+5:0] exp_b;
        exp_b = {5'(16 + i), (i == 5), beat_data(2, p2, i)};
        tests++;
        if (mon_q[i] !== exp_b) begin
          fails++;
          $display("FAIL bp_beat%0d: got %h want %h", i, mon_q[i], exp_b);
        end
      end
    end
  endtask

  task automatic test_mid_disable();
    int p3;
    @(negedge clk);
    p3         = pkt_idx[3];
    src_len[3] = 5;
    src_len[1] = 2;
    src_on     = 4'b1010;
    for (int j = 1; j <= 12; j++) begin
      logic [3:0] exp_g;
      @(negedge clk);
      if (j <= 5) exp_g = 4'b1000;
      else if (j == 7 || j == 8 || j == 10 || j == 11) exp_g = 4'b0010;
      else exp_g = 4'b0000;
      tests++;
      if (grant !== exp_g) begin
        fails++;
        $display("FAIL dis_grant j=%0d: grant=%b want %b", j, grant, exp_g);
      end
      if (j <= 5) begin
        tests++;
        if (AXIS_TX_TDATA !== beat_data(3, p3, j - 1) || s_tready[3] !== 1'b1) begin
          fails++;
          $display("FAIL dis_beat j=%0d: data=%h rdy=%b want %h/1", j, AXIS_TX_TDATA, s_tready[3], beat_data(3, p3, j - 1));
        end
      end
      if (j == 3) port_enable[3] = 1'b0;
    end
    tests++;
    if (pkt_count !== 32'd16) begin
      fails++;
      $display("FAIL dis_count: count=%0d want 16", pkt_count);
    end
    src_on      = 4'h0;
    port_enable = 4'hF;
  endtask

  task automatic test_reset_mid_packet();
    @(negedge clk);
    for (int i = 0; i < 4; i++) src_len[i] = 5;
    src_on = 4'hF;
    for (int r = 1; r <= 11; r++) begin
      logic [3:0] exp_g;
      @(posedge clk);
      #1;
      if (r == 3) reset = 1'b1;
      if (r == 5) reset = 1'b0;
      @(negedge clk);
      if (r <= 3) exp_g = 4'b0100;
      else if (r >= 6 && r <= 10) exp_g = 4'b0001;
      else exp_g = 4'b0000;
      tests++;
      if (grant !== exp_g) begin
        fails++;
        $display("FAIL rmid_grant r=%0d: grant=%b want %b", r, grant, exp_g);
      end
      if (r == 3 || r == 4) begin
        tests++;
        if (s_tready !== 4'b0000) begin
          fails++;
          $display("FAIL rmid_ready r=%0d: tready=%b want 0000", r, s_tready);
        end
      end
      if (r == 4) begin
        tests++;
        if (AXIS_TX_TVALID !== 1'b0 || pkt_count !== 32'd0) begin
          fails++;
          $display("FAIL rmid_state: tvalid=%b count=%0d want 0/0", AXIS_TX_TVALID, pkt_count);
        end
      end
    end
    tests++;
    if (pkt_count !== 32'd1) begin
      fails++;
      $display("FAIL rmid_count: count=%0d want 1", pkt_count);
    end
    src_on = 4'h0;
  endtask

  // Two single-beat packets from the same source: ARB/PASS alternate, count wraps on the first.
  task automatic test_wrap_back_to_back();
    @(negedge clk);
    force dut.pkt_count = 32'hFFFF_FFFF;
    @(posedge clk);
    #1 release dut.pkt_count;
    @(negedge clk);
    tests++;
    if (pkt_count !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL wrap_preload: count=%h want ffffffff", pkt_count);
    end
    src_len[0] = 1;
    src_on     = 4'b0001;
    for (int w = 1; w <= 4; w++) begin
      logic [3:0] exp_g;
      @(negedge clk);
      exp_g = (w % 2 == 1) ? 4'b0001 : 4'b0000;
      tests++;
      if (grant !== exp_g) begin
        fails++;
        $display("FAIL b2b_grant w=%0d: grant=%b want %b", w, grant, exp_g);
      end
      if (w == 1) begin
        tests++;
        if (AXIS_TX_TLAST !== 1'b1 || AXIS_TX_TVALID !== 1'b1) begin
          fails++;
          $display("FAIL b2b_last: tlast=%b tvalid=%b want 1/1", AXIS_TX_TLAST, AXIS_TX_TVALID);
        end
      end
      if (w == 2 || w == 4) begin
        tests++;
        if (pkt_count !== 32'(w / 2 - 1)) begin
          fails++;
          $display("FAIL wrap_count w=%0d: count=%h want %h", w, pkt_count, 32'(w / 2 - 1));
        end
      end
    end
    src_on = 4'h0;
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_enable_mask();
    test_backpressure();
    test_mid_disable();
    test_reset_mid_packet();
    test_wrap_back_to_back();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
